// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-master BurstRAM arbiter.
// Imported by the arbiter top and its round-robin helper.
package burst_ram_arbiter_pkg;

    localparam int BEAT_W = 64;
    localparam int MASK_W = BEAT_W / 8;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_WR_DATA = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/burst_ram_arbiter_rr.sv
// Two-way round-robin pick with a registered last-grant pointer.
// On a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       grant_o,
    output logic       valid_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        valid_o = |req_i;
        unique case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = ~last_q;
            default: grant_o = 1'b0;
        endcase
        last_d = (advance_i && valid_o) ? grant_o : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM command/data port between two masters, granting
// whole bursts round-robin once the RAM reports calibration complete.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rq0_cmd,
    input  logic                      rq0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] rq0_addr,
    input  logic [BEAT_W-1:0]         rq0_wr_data,
    input  logic [MASK_W-1:0]         rq0_data_mask,
    output logic                      rq0_ack,
    output logic                      rq0_wr_beat,
    output logic [BEAT_W-1:0]         rq0_rd_data,
    output logic                      rq0_rd_data_valid,
    input  logic                      rq1_cmd,
    input  logic                      rq1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] rq1_addr,
    input  logic [BEAT_W-1:0]         rq1_wr_data,
    input  logic [MASK_W-1:0]         rq1_data_mask,
    output logic                      rq1_ack,
    output logic                      rq1_wr_beat,
    output logic [BEAT_W-1:0]         rq1_rd_data,
    output logic                      rq1_rd_data_valid,
    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [BEAT_W-1:0]         br_wr_data,
    output logic [MASK_W-1:0]         br_data_mask,
    input  logic [BEAT_W-1:0]         br_rd_data,
    input  logic                      br_rd_data_valid,
    input  logic                      br_init_calib,
    input  logic                      br_busy
);

    localparam int CNT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(BURST_COUNT - 1);
    localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(BURST_COUNT - 2);

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      cmd_q, cmd_d;
    logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic grant;
    logic grant_vld;
    logic go;

    // RAM readiness is only checked when a new burst is about to start.
    assign go = (state_q == ST_IDLE) && br_init_calib && !br_busy && grant_vld;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({rq1_cmd_en, rq0_cmd_en}),
        .advance_i (go),
        .grant_o   (grant),
        .valid_o   (grant_vld)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go) begin
                    owner_d = grant;
                    cmd_d   = grant ? rq1_cmd : rq0_cmd;
                    addr_d  = grant ? rq1_addr : rq0_addr;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                cnt_d   = '0;
                state_d = (cmd_q == CMD_WRITE) ? ST_WR_DATA : ST_RD_WAIT;
            end
            ST_WR_DATA: begin
                if (cnt_q == LAST_WR) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RD_WAIT: begin
                if (br_rd_data_valid) begin
                    if (cnt_q == LAST_RD) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    logic in_cmd;
    logic beat;
    logic rd_v;

    // Beat 0 of a write leaves together with the command.
    always_comb begin
        in_cmd = (state_q == ST_CMD);
        beat   = (in_cmd && cmd_q == CMD_WRITE) || (state_q == ST_WR_DATA);
        rd_v   = (state_q == ST_RD_WAIT) && br_rd_data_valid;

        br_cmd_en    = in_cmd;
        br_cmd       = in_cmd & cmd_q;
        br_addr      = in_cmd ? addr_q : '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        if (beat) begin
            br_wr_data = owner_q ? rq1_wr_data : rq0_wr_data;
        end
        if (state_q != ST_IDLE) begin
            br_data_mask = owner_q ? rq1_data_mask : rq0_data_mask;
        end

        rq0_ack           = in_cmd & ~owner_q;
        rq1_ack           = in_cmd & owner_q;
        rq0_wr_beat       = beat & ~owner_q;
        rq1_wr_beat       = beat & owner_q;
        rq0_rd_data_valid = rd_v & ~owner_q;
        rq1_rd_data_valid = rd_v & owner_q;
    end

    assign rq0_rd_data = br_rd_data;
    assign rq1_rd_data = br_rd_data;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small BurstRAM model
// (read data valid 6 cycles after the command, 4 beats per burst).
module tb_burst_ram_arbiter;
    import burst_ram_arbiter_pkg::*;

    localparam int DW  = 4;
    localparam int BC  = 4;
    localparam int LAT = 6;
    localparam logic [63:0] IDLE_PAT = 64'hC0DE_0000_FACE_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd0, en0, cmd1, en1;
    logic [DW-1:0] addr0, addr1;
    logic [63:0]   wd0, wd1;
    logic [7:0]    mask0, mask1;
    logic          ack0, beat0, v0, ack1, beat1, v1;
    logic [63:0]   rd0, rd1;
    logic          br_cmd, br_cmd_en;
    logic [DW-1:0] br_addr;
    logic [63:0]   br_wr_data, br_rd_data;
    logic [7:0]    br_data_mask;
    logic          br_rd_data_valid, cal, busy, stray;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst_n(rst_n),
        .rq0_cmd(cmd0), .rq0_cmd_en(en0), .rq0_addr(addr0),
        .rq0_wr_data(wd0), .rq0_data_mask(mask0),
        .rq0_ack(ack0), .rq0_wr_beat(beat0),
        .rq0_rd_data(rd0), .rq0_rd_data_valid(v0),
        .rq1_cmd(cmd1), .rq1_cmd_en(en1), .rq1_addr(addr1),
        .rq1_wr_data(wd1), .rq1_data_mask(mask1),
        .rq1_ack(ack1), .rq1_wr_beat(beat1),
        .rq1_rd_data(rd1), .rq1_rd_data_valid(v1),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_init_calib(cal), .br_busy(busy)
    );

    logic [63:0] wb0 [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    logic [1:0] i0_q;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) i0_q <= 2'd0;
        else if (beat0) i0_q <= i0_q + 2'd1;
    assign wd0 = wb0[i0_q];
    assign wd1 = 64'h5555_5555_5555_5555;
    assign mask0 = 8'hF0;
    assign mask1 = 8'h0F;

    logic [63:0] mem [64];
    logic [5:0]  wadr_q, wa, rd_base;
    int          rd_t;
    logic        rd_win;
    assign wa = br_cmd_en ? {br_addr, 2'b00} : wadr_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wadr_q <= '0;
            rd_t <= 0;
            rd_base <= '0;
        end else begin
            if (beat0 | beat1) begin
                mem[wa] <= br_wr_data;
                wadr_q <= wa + 6'd1;
            end
            if (br_cmd_en && br_cmd == CMD_READ) begin
                rd_t <= 1;
                rd_base <= {br_addr, 2'b00};
            end else if (rd_t != 0) begin
                rd_t <= (rd_t == LAT + BC - 1) ? 0 : rd_t + 1;
            end
        end
    end
    assign rd_win = (rd_t >= LAT) && (rd_t < LAT + BC);
    assign br_rd_data_valid = rd_win || stray;
    assign br_rd_data = rd_win ? mem[rd_base + 6'(rd_t - LAT)] : IDLE_PAT;

    int total = 0;
    int bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        stray = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, " cmd_en"}, br_cmd_en, 0);
        chk({nm, " cmd"}, br_cmd, 0);
        chk({nm, " addr"}, br_addr, 0);
        chk({nm, " wr_data"}, br_wr_data, 0);
        chk({nm, " mask"}, br_data_mask, 0);
        chk({nm, " acks"}, {ack0, ack1}, 0);
        chk({nm, " beats"}, {beat0, beat1}, 0);
        chk({nm, " rdv"}, {v0, v1}, 0);
        chk({nm, " rd_data"}, rd0, IDLE_PAT);
        chk({nm, " rd_data1"}, rd1, IDLE_PAT);
    endtask

    task automatic wait_ack(input string nm, output int who, output int cyc);
        who = -1;
        cyc = 0;
        for (int i = 0; i < 40 && who < 0; i++) begin
            tick;
            cyc++;
            if (ack0) who = 0;
            else if (ack1) who = 1;
        end
        chk({nm, " ack seen"}, who >= 0, 1);
    endtask

    task automatic read_burst1(input string nm);
        int beats;
        beats = 0;
        for (int i = 0; i < 30 && beats < BC; i++) begin
            tick;
            chk({nm, " rq0 rdv quiet"}, v0, 0);
            if (v1) begin
                chk({nm, " rd beat"}, rd1, wb0[beats]);
                beats++;
            end
        end
        chk({nm, " beat count"}, beats, BC);
    endtask

    typedef struct {
        logic c, b, e0, e1;
        logic x_en, x_a0, x_a1;
        logic [DW-1:0] x_addr;
    } vec_t;
    vec_t vt [7];

    initial begin
        int who, cyc;
        cal = 0; busy = 0; en0 = 0; en1 = 0; stray = 0;
        cmd0 = 0; cmd1 = 0; addr0 = 0; addr1 = 0;

        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

        // reset: inputs active but reset held
        cal = 1; en0 = 1; cmd0 = 1; addr0 = 4'd7;
        #12;
        check_quiet("reset");
        tick;
        check_quiet("reset2");
        en0 = 0;

        for (int k = 0; k < 7; k++) begin
            do_reset;
            cal = vt[k].c; busy = vt[k].b;
            cmd0 = 0; cmd1 = 0; addr0 = 4'd3; addr1 = 4'd5;
            en0 = vt[k].e0; en1 = vt[k].e1;
            tick;
            chk($sformatf("vec%0d cmd_en", k), br_cmd_en, vt[k].x_en);
            chk($sformatf("vec%0d ack0", k), ack0, vt[k].x_a0);
            chk($sformatf("vec%0d ack1", k), ack1, vt[k].x_a1);
            chk($sformatf("vec%0d addr", k), br_addr, vt[k].x_addr);
            en0 = 0; en1 = 0;
        end

        // calibration / busy gate, then write burst at addr 2
        do_reset;
        cal = 0; busy = 0;
        en0 = 1; cmd0 = CMD_WRITE; addr0 = 4'd2;
        repeat (3) begin tick; chk("calib gate", br_cmd_en, 0); end
        cal = 1; busy = 1;
        repeat (2) begin tick; chk("busy gate", br_cmd_en, 0); end
        busy = 0;
        tick;
        chk("wr ack0", ack0, 1);
        chk("wr cmd_en", br_cmd_en, 1);
        chk("wr cmd", br_cmd, 1);
        chk("wr addr", br_addr, 2);
        chk("wr mask", br_data_mask, 8'hF0);
        chk("wr beat0", beat0, 1);
        chk("wr data0", br_wr_data, wb0[0]);
        en0 = 0;
        for (int i = 1; i < BC; i++) begin
            tick;
            chk("wr beat", beat0, 1);
            chk("wr data", br_wr_data, wb0[i]);
            chk("wr no cmd", br_cmd_en, 0);
        end
        tick;
        chk("wr end beat", beat0, 0);
        chk("wr end mask", br_data_mask, 0);
        for (int i = 0; i < BC; i++) chk("ram word", mem[8 + i], wb0[i]);

        // rq1 read back, then earliest re-grant after the last beat
        en1 = 1; cmd1 = CMD_READ; addr1 = 4'd2;
        tick;
        chk("rd ack1", ack1, 1);
        chk("rd ack0", ack0, 0);
        chk("rd cmd", br_cmd, 0);
        en1 = 0;
        read_burst1("rd1");
        en0 = 1; cmd0 = CMD_READ; addr0 = 4'd0;
        tick;
        chk("post rd idle", br_cmd_en, 0);
        tick;
        chk("post rd grant", ack0, 1);
        en0 = 0;

        // stray valid in IDLE, then simultaneous requests
        do_reset;
        stray = 1;
        tick;
        chk("stray v0", v0, 0);
        chk("stray v1", v1, 0);
        stray = 0;
        cmd0 = CMD_READ; cmd1 = CMD_READ; addr0 = 4'd0; addr1 = 4'd1;
        en0 = 1; en1 = 1;
        tick;
        chk("tie ack0", ack0, 1);
        chk("tie ack1", ack1, 0);
        en0 = 0;
        wait_ack("tie second", who, cyc);
        chk("tie second who", who, 1);
        en1 = 0;
        repeat (12) tick;
        en0 = 1; en1 = 1;
        tick;
        chk("tie repeat ack0", ack0, 1);
        en0 = 0; en1 = 0;
        repeat (12) tick;

        // both held continuously: strict alternation, back-to-back spacing
        do_reset;
        cmd0 = CMD_WRITE; cmd1 = CMD_WRITE; addr0 = 4'd4; addr1 = 4'd5;
        en0 = 1; en1 = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("rr%0d", k), who, cyc);
            chk($sformatf("rr%0d who", k), who, k % 2);
            if (k > 0) chk($sformatf("rr%0d gap", k), cyc, BC + 1);
        end
        en0 = 0; en1 = 0;
        repeat (6) tick;

        // reset during write beat 2, then a clean read
        do_reset;
        en0 = 1; cmd0 = CMD_WRITE; addr0 = 4'd3;
        tick;
        chk("mid ack0", ack0, 1);
        en0 = 0;
        tick;
        tick;
        chk("mid beat2", beat0, 1);
        #2 rst_n = 0;
        #1 check_quiet("midrst");
        tick;
        rst_n = 1;
        en1 = 1; cmd1 = CMD_READ; addr1 = 4'd2;
        tick;
        chk("after rst ack1", ack1, 1);
        en1 = 0;
        read_burst1("rd2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/burst_ram_arbiter.md
# burst_ram_arbiter

Two-requester arbiter that shares one BurstRAM command/data port between independent masters, e.g. an instruction-fetch cache and the RAMIO data cache. Grants whole bursts with round-robin fairness, forwards write beats from and read beats to the owning requester only, and holds off all traffic until the RAM reports calibration complete. Sits between the cache controllers and the BurstRAM / DDR3 IP wrapper.

## Interface
- DEPTH_BITWIDTH, 4: width of the burst-RAM address (64-bit words).
- BURST_COUNT, 4: 64-bit beats per burst, read or write; ≥2.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rqN_cmd  in  1  (N = 0,1) 0: read, 1: write.
- rqN_cmd_en  in  1  request level; held with cmd/addr stable until rqN_ack.
- rqN_addr  in  DEPTH_BITWIDTH  burst start address.
- rqN_wr_data  in  64  current write beat.
- rqN_data_mask  in  8  forwarded unchanged to br_data_mask.
- rqN_ack  out  1  one-cycle pulse; command issued to RAM this cycle.
- rqN_wr_beat  out  1  rqN_wr_data sampled this cycle; requester advances to the next beat.
- rqN_rd_data  out  64  br_rd_data broadcast.
- rqN_rd_data_valid  out  1  br_rd_data_valid gated by ownership.
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  to RAM.
- br_rd_data  in  64; br_rd_data_valid, br_init_calib, br_busy  in  1.

## Operation
- States: IDLE, CMD, WR_DATA, RD_WAIT.
- IDLE: when br_init_calib=1, br_busy=0 and any rqN_cmd_en=1, pick a winner and latch owner, cmd, addr; go to CMD.
- Round-robin: register last_grant, reset value 1. One request wins alone. With both requesting, the requester ≠ last_grant wins. last_grant updates on every grant.
- CMD, one cycle: br_cmd_en=1; br_cmd and br_addr come from the latched values; rqOwner_ack=1.
  - Write: beat 0 also goes out, so br_wr_data = owner wr_data and rqOwner_wr_beat=1. Next state WR_DATA.
  - Read: next state RD_WAIT.
- WR_DATA: BURST_COUNT-1 cycles, each with rqOwner_wr_beat=1 and br_wr_data muxed from the owner. Beat counter width is clog2(BURST_COUNT). After the last beat, return to IDLE.
- RD_WAIT: count br_rd_data_valid beats and forward them as rqOwner_rd_data_valid. The cycle after the BURST_COUNT-th beat, the state is IDLE.
- br_rd_data_valid outside RD_WAIT is ignored; no requester sees a valid.
- The non-owner's cmd_en is ignored until IDLE. It is never dropped, only deferred.
- br_data_mask = owner data_mask while busy, 0 in IDLE.

## Timing
- Reset (async): state IDLE, last_grant=1, counter 0.
  - All outputs 0: br_cmd_en, br_cmd, br_addr, br_wr_data, ack, wr_beat, rd_data_valid.
  - rd_data continues to mirror br_rd_data.
- Grant latency: cmd_en high in IDLE at edge t gives CMD (br_cmd_en, ack) during cycle t+1.
- Write burst occupies cycles t+1 … t+BURST_COUNT. IDLE at t+BURST_COUNT+1; earliest next CMD at t+BURST_COUNT+2.
- Read: IDLE the cycle after the last valid beat. rqN_rd_data_valid is combinational from br_rd_data_valid, so there are zero added cycles.
- br_busy or !br_init_calib while in IDLE blocks the grant. While not in IDLE it is not checked.
- Reset mid-burst abandons the burst. The requester must re-issue.

## Structure
- Package burst_ram_arbiter_pkg holds:
  - the state enum;
  - CMD_READ=0 and CMD_WRITE=1;
  - the width constant for the 64-bit beat.
- Sub-module rr_arbiter2 holds the two-way round-robin pick and the last_grant register. Its inputs are req[1:0] and an advance strobe; its outputs are grant index and valid.
- Remaining logic is the FSM, beat counter and muxes.

## Test plan
All scenarios run against BurstRAM with CYCLES_BEFORE_DATA_VALID=6 and BURST_COUNT=4.

1. Calibration gate: rq0 write requested before init_calib → no br_cmd_en until br_busy=0 and init_calib=1. Then ack 1 cycle after.
2. rq0 write at addr 2 with beats 0x11…11, 0x22…22, 0x33…33, 0x44…44 → rq0_wr_beat high exactly 4 consecutive cycles starting with br_cmd_en. RAM words 8–11 hold those values.
3. rq1 read at addr 2 → rq1_rd_data_valid for 4 beats carrying the values from scenario 2. rq0_rd_data_valid stays 0 throughout.
4. Both requesters assert cmd_en in the same cycle after reset → rq0 granted first, rq1 granted at the next IDLE. On a repeat simultaneous request, rq0 wins (it was not the last grant).
5. rq0 held continuously asserting while rq1 requests → grants alternate 0,1,0,1. Neither requester is starved.
6. rst_n pulled low during WR_DATA beat 2 → all outputs 0 immediately, state IDLE. A fresh rq1 read afterwards completes normally.
